// File: rtl/cpu_program_sequencer.sv
// Instruction-issue master for the 8-register core: runs an 8-entry register
// preload through the manual-load path, then streams program memory through the ALU path.
module cpu_program_sequencer #(
  parameter int          AW        = 5,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          pre_we,
  input  logic [2:0]    pre_addr,
  input  logic [31:0]   pre_data,
  input  logic          start,
  output logic [31:0]   INS,
  output logic          LO,
  output logic          WR,
  output logic [2:0]    RSM,
  output logic [31:0]   ManIn,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   pc
);
  localparam int          DEPTH   = 2**AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_RUN, S_DONE} state_e;

  logic [31:0]      mem [DEPTH];
  logic [7:0][31:0] pre_val_q;
  logic [7:0]       pre_vld_q;

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [AW:0] pc_q, pc_d, len_q, len_d, pc_inc;
  logic [31:0] ins_q, ins_d, man_q, man_d, cur_word, next_word;
  logic [2:0]  rsm_q, rsm_d;
  logic        lo_q, lo_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d;
  logic        busy_now, prog_en, pre_en;

  assign busy_now  = (state_q == S_PRE) || (state_q == S_RUN);
  assign prog_en   = prog_we && !busy_now;
  assign pre_en    = pre_we && !busy_now;
  assign pc_inc    = pc_q + (AW+1)'(1);
  assign cur_word  = mem[pc_q[AW-1:0]];
  assign next_word = mem[pc_d[AW-1:0]];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    pc_d    = pc_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d = S_PRE;
        k_d     = '0;
        pc_d    = '0;
        len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
      end
      S_PRE: if (k_q == 3'd7) begin
        state_d = (len_q == '0) ? S_DONE : S_RUN;
        pc_d    = '0;
      end else begin
        k_d = k_q + 3'd1;
      end
      S_RUN: if (cur_word == HALT_WORD) begin
        state_d = S_DONE;
      end else begin
        pc_d = pc_inc;
        if (pc_inc == len_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    ins_d  = '0;
    lo_d   = 1'b0;
    wr_d   = 1'b0;
    rsm_d  = '0;
    man_d  = '0;
    busy_d = (state_d == S_PRE) || (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    case (state_d)
      S_PRE: begin
        lo_d  = 1'b1;
        rsm_d = k_d;
        // A table write in the start cycle must reach the first preload beat.
        if (pre_en && pre_addr == k_d) begin
          man_d = pre_data;
          wr_d  = 1'b1;
        end else begin
          man_d = pre_val_q[k_d];
          wr_d  = pre_vld_q[k_d];
        end
      end
      S_RUN: begin
        ins_d = next_word;
        wr_d  = (next_word != HALT_WORD);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      pc_q      <= '0;
      len_q     <= '0;
      ins_q     <= '0;
      lo_q      <= 1'b0;
      wr_q      <= 1'b0;
      rsm_q     <= '0;
      man_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pre_vld_q <= '0;
      pre_val_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      ins_q   <= ins_d;
      lo_q    <= lo_d;
      wr_q    <= wr_d;
      rsm_q   <= rsm_d;
      man_q   <= man_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (pre_en) begin
        pre_val_q[pre_addr] <= pre_data;
        pre_vld_q[pre_addr] <= 1'b1;
      end
    end
  end

  // Program memory survives reset.
  always_ff @(posedge clk) begin
    if (prog_en) mem[prog_addr] <= prog_data;
  end

  assign INS   = ins_q;
  assign LO    = lo_q;
  assign WR    = wr_q;
  assign RSM   = rsm_q;
  assign ManIn = man_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign pc    = pc_q;
endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Scoreboard bench for cpu_program_sequencer: per-cycle expected outputs are
// queued from a reference model at start and popped as the DUT issues.
module tb_cpu_program_sequencer;
  localparam int          AW    = 5;
  localparam int          DEPTH = 32;
  localparam logic [31:0] HALT  = 32'hFFFFFFFF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          prog_we = 1'b0, pre_we = 1'b0, start = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0]   prog_data = '0, pre_data = '0;
  logic [AW:0]   prog_len = '0;
  logic [2:0]    pre_addr = '0;
  logic [31:0]   INS, ManIn;
  logic          LO, WR, busy, done;
  logic [2:0]    RSM;
  logic [AW:0]   pc;

  cpu_program_sequencer #(.AW(AW), .HALT_WORD(HALT)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .pre_we(pre_we),
    .pre_addr(pre_addr), .pre_data(pre_data), .start(start),
    .INS(INS), .LO(LO), .WR(WR), .RSM(RSM), .ManIn(ManIn),
    .busy(busy), .done(done), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ins;
    logic        lo;
    logic        wr;
    logic [2:0]  rsm;
    logic [31:0] man;
    logic        busy;
    logic        done;
    logic [AW:0] pc;
    logic        chk_man;
  } exp_t;

  typedef struct {
    int    len;
    int    cyc;
    int    fpc;
    string nm;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[6];
  logic [31:0] mmem[DEPTH];
  logic [31:0] mval[8];
  logic        mvld[8];
  int          total = 0, bad = 0;

  function automatic logic [31:0] pat(input int i);
    return 32'h0100_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  task automatic check_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input int n, input exp_t e);
    total++;
    if ({INS, LO, WR, RSM, busy, done, pc} !== {e.ins, e.lo, e.wr, e.rsm, e.busy, e.done, e.pc} ||
        (e.chk_man && ManIn !== e.man)) begin
      bad++;
      $display("FAIL %s cyc%0d: got ins=%h lo=%b wr=%b rsm=%0d man=%h busy=%b done=%b pc=%0d want ins=%h lo=%b wr=%b rsm=%0d man=%h busy=%b done=%b pc=%0d",
               nm, n, INS, LO, WR, RSM, ManIn, busy, done, pc,
               e.ins, e.lo, e.wr, e.rsm, e.man, e.busy, e.done, e.pc);
    end
  endtask

  task automatic check_zero(input string nm);
    total++;
    if ({INS, LO, WR, RSM, ManIn, busy, done, pc} !== '0) begin
      bad++;
      $display("FAIL %s: got ins=%h lo=%b wr=%b rsm=%0d man=%h busy=%b done=%b pc=%0d want all zero",
               nm, INS, LO, WR, RSM, ManIn, busy, done, pc);
    end
  endtask

  task automatic prog_write(input int a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    mmem[a] = d;
  endtask

  task automatic pre_write(input int a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = 3'(a); pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    mval[a] = d; mvld[a] = 1'b1;
  endtask

  // Expected cycles from start sample to done, and final pc, come from the caller.
  task automatic run_check(input int len, input int exp_cyc, input int exp_pc,
                           input string nm, input int inj, input bit coll);
    exp_t e;
    int   plen, p, first;
    if (coll) begin
      prog_we = 1'b1; prog_addr = '0; prog_data = 32'h04221800;
      pre_we = 1'b1; pre_addr = 3'd0; pre_data = 32'h00000055;
      mmem[0] = 32'h04221800; mval[0] = 32'h00000055; mvld[0] = 1'b1;
    end
    for (int k = 0; k < 8; k++) begin
      e = '0; e.lo = 1'b1; e.wr = mvld[k]; e.rsm = 3'(k); e.man = mval[k];
      e.chk_man = mvld[k]; e.busy = 1'b1;
      sb.push_back(e);
    end
    plen = (len > DEPTH) ? DEPTH : len;
    p = 0;
    for (int i = 0; i < plen; i++) begin
      e = '0; e.ins = mmem[i]; e.busy = 1'b1; e.pc = (AW+1)'(i);
      if (mmem[i] == HALT) begin
        sb.push_back(e); p = i;
        break;
      end
      e.wr = 1'b1;
      sb.push_back(e); p = i + 1;
    end
    e = '0; e.done = 1'b1; e.pc = (AW+1)'(p);
    sb.push_back(e);

    start = 1'b1; prog_len = (AW+1)'(len);
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0; pre_we = 1'b0;
    first = -1;
    for (int n = 1; sb.size() > 0; n++) begin
      e = sb.pop_front();
      check_out(nm, n, e);
      if (done && first < 0) first = n;
      if (n == inj) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = 32'hDEADBEEF;
        pre_we = 1'b1; pre_addr = 3'd0; pre_data = 32'h77;
      end else begin
        start = 1'b0; prog_we = 1'b0; pre_we = 1'b0;
      end
      @(negedge clk);
    end
    check_int({nm, " cycles"}, first, exp_cyc);
    check_int({nm, " pc"}, int'(pc), exp_pc);
  endtask

  initial begin
    vt[0] = '{0,  9,  0,  "preload_only"};
    vt[1] = '{3,  12, 3,  "run3"};
    vt[2] = '{1,  10, 1,  "run1"};
    vt[3] = '{32, 41, 32, "run_full"};
    vt[4] = '{45, 41, 32, "clamp45"};
    vt[5] = '{63, 41, 32, "clamp63"};
    for (int k = 0; k < 8; k++) begin mval[k] = '0; mvld[k] = 1'b0; end
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;

    #1 reset = 1'b0;
    #1 check_zero("reset_async");
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("idle_after_reset");

    pre_write(2, 32'h0000000A);
    pre_write(5, 32'h00000003);
    run_check(vt[0].len, vt[0].cyc, vt[0].fpc, vt[0].nm, -1, 1'b0);

    for (int i = 0; i < DEPTH; i++) prog_write(i, pat(i));
    for (int r = 1; r < 6; r++) begin
      if (r == 3) pre_write(7, 32'h12345678);
      run_check(vt[r].len, vt[r].cyc, vt[r].fpc, vt[r].nm, -1, 1'b0);
    end

    prog_write(1, HALT);
    run_check(4, 11, 1, "halt", -1, 1'b0);
    prog_write(1, pat(1));

    run_check(5, 14, 5, "ignored_reqs", 10, 1'b0);
    run_check(1, 10, 1, "restart_orig", -1, 1'b0);

    start = 1'b1; prog_len = 6'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_zero("reset_mid_run");
    for (int k = 0; k < 8; k++) mvld[k] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("idle_after_mid_reset");
    run_check(2, 11, 2, "post_reset", -1, 1'b0);

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_check(1, 10, 1, "same_cycle_wr_start", -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
